// File: rtl/dm_responder.sv
// Data-memory responder: one word read/write per req/ack handshake, a fixed
// number of wait states before the access, and err for bad addresses.
module dm_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam bit         ZERO_WAIT = (WAIT_CYC == 0);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic                r_ack;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_bad_addr;
  logic                w_acc_fire;
  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_idx;
  logic [31:0]         w_acc_wdata;

  assign w_bad_addr = (i_addr[1:0] != 2'b00) || (i_addr[31:ADDR_W+2] != '0);

  // Select the access source: live inputs for a zero-wait build, latched fields otherwise.
  always_comb begin
    w_acc_fire  = 1'b0;
    w_acc_we    = r_we;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (ZERO_WAIT && i_req && !w_bad_addr) begin
          w_acc_fire  = 1'b1;
          w_acc_we    = i_we;
          w_acc_idx   = i_addr[ADDR_W+1:2];
          w_acc_wdata = i_wdata;
        end else begin
          w_acc_fire  = 1'b0;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_acc_fire = 1'b1;
        end else begin
          w_acc_fire = 1'b0;
        end
      end
      default: w_acc_fire = 1'b0;
    endcase
  end

  // Memory write port; the array is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (w_acc_fire && w_acc_we) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  // Transaction FSM with registered ack/err/rdata.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (i_req) begin
            r_we    <= i_we;
            r_idx   <= i_addr[ADDR_W+1:2];
            r_wdata <= i_wdata;
            if (w_bad_addr) begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
            end else if (ZERO_WAIT) begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              if (!w_acc_we) begin
                r_rdata <= r_mem[w_acc_idx];
              end
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
            r_ack   <= 1'b1;
            r_err   <= 1'b0;
            if (!w_acc_we) begin
              r_rdata <= r_mem[w_acc_idx];
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack   = r_ack;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;
  assign o_busy  = (r_state != S_IDLE);

endmodule
